// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared NPU constants and drain FSM state encodings
package npu_pkg;

    localparam int DEF_ARRAY_M   = 8;
    localparam int DEF_ACT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } drain_state_t;

endpackage

// File: rtl/drain_fifo.sv
// rtl/drain_fifo.sv - small synchronous FIFO holding {last, data} rows
module drain_fifo #(
    parameter  int DATA_WIDTH = 65,
    parameter  int DEPTH      = 2,
    localparam int AW         = $clog2(DEPTH),
    localparam int CW         = AW + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [CW-1:0]         count,
    output logic                  empty,
    output logic                  full
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Head is masked to zero when empty so the stream shows clean data after reset
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/obuf_drain.sv
// rtl/obuf_drain.sv - walks O_buffer rows and streams each row out as one beat
module obuf_drain
    import npu_pkg::*;
#(
    parameter int ARRAY_M    = DEF_ARRAY_M,
    parameter int ACT_WIDTH  = DEF_ACT_WIDTH,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [ADDR_WIDTH-1:0]        base_addr,
    input  logic [ADDR_WIDTH:0]          num_rows,
    output logic                         busy,
    output logic                         done,
    output logic [ADDR_WIDTH-1:0]        rd_addr,
    input  logic [ACT_WIDTH*ARRAY_M-1:0] rd_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [ACT_WIDTH*ARRAY_M-1:0] m_data,
    output logic                         m_last
);

    localparam int DW = ACT_WIDTH * ARRAY_M;
    localparam int RW = ADDR_WIDTH + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]   OCC_MAX = FIFO_DEPTH[CW:0];
    localparam logic [RW-1:0] ONE_R   = RW'(1);

    drain_state_t  state, state_next;
    logic [RW-1:0] rows_q;
    logic [RW-1:0] rows_left;
    logic [RW-1:0] beat_cnt;
    logic          inflight;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW:0]   occ;
    logic          issue;
    logic          push;
    logic          pop;
    logic          last_tag;

    assign pop      = m_valid && m_ready;
    assign push     = inflight && !fifo_full;
    assign last_tag = (beat_cnt == rows_q - ONE_R);
    // Occupancy after this cycle's pop; lets a full FIFO being drained still issue
    assign occ      = {1'b0, fifo_count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    assign issue    = (state == ST_READ) && (rows_left != '0) && (occ < OCC_MAX);

    assign busy    = (state == ST_READ) || (state == ST_DRAIN);
    assign done    = (state == ST_DONE);
    assign m_valid = !fifo_empty;

    always_comb begin
        state_next = state;
        case (state)
            // A zero-row launch passes through DRAIN so busy is visible for one cycle
            ST_IDLE:  if (start) state_next = (num_rows == '0) ? ST_DRAIN : ST_READ;
            ST_READ:  if (issue && rows_left == ONE_R) state_next = ST_DRAIN;
            ST_DRAIN: if (!inflight && (fifo_empty || (fifo_count == CW'(1) && pop)))
                          state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            rd_addr   <= '0;
            rows_q    <= '0;
            rows_left <= '0;
            beat_cnt  <= '0;
            inflight  <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= issue;
            if (state == ST_IDLE && start) begin
                rd_addr   <= base_addr;
                rows_q    <= num_rows;
                rows_left <= num_rows;
                beat_cnt  <= '0;
            end else if (issue) begin
                rd_addr   <= rd_addr + ADDR_WIDTH'(1);
                rows_left <= rows_left - ONE_R;
            end
            if (push) begin
                beat_cnt <= beat_cnt + ONE_R;
            end
        end
    end

    drain_fifo #(
        .DATA_WIDTH(DW + 1),
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .din  ({last_tag, rd_data}),
        .pop  (pop),
        .dout ({m_last, m_data}),
        .count(fifo_count),
        .empty(fifo_empty),
        .full (fifo_full)
    );

endmodule
